// File: rtl/pattern_monitor_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pattern_monitor_pkg
// Purpose  : Shared state encoding, period constants and phase helper for
//            the 1,0,0 serial pattern monitor.
// Revision : 1.0 - initial release
// ============================================================================
package pattern_monitor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HUNT   = 2'd0;
    localparam state_t CHECK  = 2'd1;
    localparam state_t LOCKED = 2'd2;

    localparam int PERIOD = 3;

    localparam logic EXPECTED [0:PERIOD-1] = '{1'b1, 1'b0, 1'b0};

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return (p == 2'(PERIOD - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_monitor_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that holds at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pattern_monitor
// Purpose  : Locks to a repeating 1,0,0 serial stream, then flags, counts and
//            tracks loss of lock on bit errors. Optional history/first-error
//            outputs are enabled by PATTERN_MONITOR_HISTORY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_monitor
    import pattern_monitor_pkg::*;
#(
    parameter int LOCK_N = 2,
    parameter int LOSS_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] period_count
`ifdef PATTERN_MONITOR_HISTORY_EN
    ,
    output logic [7:0]       history,
    output logic [1:0]       first_err_phase
`endif
);

    localparam logic [3:0] C_LOCK_N = 4'(LOCK_N);
    localparam logic [3:0] C_LOSS_N = 4'(LOSS_N);

    state_t           r_state;
    logic [1:0]       r_phase;
    logic [3:0]       r_good;
    logic [3:0]       r_bad;
    logic             r_locked;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_period_count;

    state_t           w_state_nxt;
    logic [1:0]       w_phase_nxt;
    logic [3:0]       w_good_nxt;
    logic [3:0]       w_bad_nxt;
    logic             w_err;
    logic             w_period_inc;
    logic             w_match;
    logic             w_wrap;

    assign w_match = (in_bit == EXPECTED[r_phase]);
    assign w_wrap  = (r_phase == 2'(PERIOD - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_good_nxt   = r_good;
        w_bad_nxt    = r_bad;
        w_err        = 1'b0;
        w_period_inc = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (in_bit) begin
                        w_state_nxt = CHECK;
                        w_phase_nxt = 2'd1;
                        w_good_nxt  = 4'd0;
                    end
                end
                CHECK: begin
                    if (w_match) begin
                        w_phase_nxt = next_phase(r_phase);
                        if (w_wrap) begin
                            if (r_good + 4'd1 == C_LOCK_N) begin
                                w_state_nxt = LOCKED;
                                w_good_nxt  = 4'd0;
                                w_bad_nxt   = 4'd0;
                            end else begin
                                w_good_nxt = r_good + 4'd1;
                            end
                        end
                    end else if (in_bit) begin
                        // A stray 1 may be the true period start: realign here.
                        w_phase_nxt = 2'd1;
                        w_good_nxt  = 4'd0;
                    end else begin
                        w_state_nxt = HUNT;
                        w_phase_nxt = 2'd0;
                        w_good_nxt  = 4'd0;
                    end
                end
                LOCKED: begin
                    w_phase_nxt = next_phase(r_phase);
                    if (w_match) begin
                        w_bad_nxt    = 4'd0;
                        w_period_inc = w_wrap;
                    end else begin
                        w_err = 1'b1;
                        if (r_bad + 4'd1 == C_LOSS_N) begin
                            w_state_nxt = HUNT;
                            w_phase_nxt = 2'd0;
                            w_bad_nxt   = 4'd0;
                        end else begin
                            w_bad_nxt    = r_bad + 4'd1;
                            w_period_inc = w_wrap;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_phase_nxt = 2'd0;
                    w_good_nxt  = 4'd0;
                    w_bad_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= HUNT;
            r_phase        <= 2'd0;
            r_good         <= 4'd0;
            r_bad          <= 4'd0;
            r_locked       <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_period_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_good      <= w_good_nxt;
            r_bad       <= w_bad_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err;
            if (w_period_inc) begin
                r_period_count <= r_period_count + 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_count (
        .clk   (clk),
        .reset (reset),
        .inc   (w_err),
        .clr   (1'b0),
        .count (err_count)
    );

    assign locked       = r_locked;
    assign err_pulse    = r_err_pulse;
    assign period_count = r_period_count;

`ifdef PATTERN_MONITOR_HISTORY_EN
    logic [7:0] r_history;
    logic [1:0] r_first_err_phase;

    // 2'b11 is never a real phase, so it doubles as "no error yet".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_history         <= 8'd0;
            r_first_err_phase <= 2'b11;
        end else begin
            if (in_valid) begin
                r_history <= {r_history[6:0], in_bit};
            end
            if (w_err && (r_first_err_phase == 2'b11)) begin
                r_first_err_phase <= r_phase;
            end
        end
    end

    assign history         = r_history;
    assign first_err_phase = r_first_err_phase;
`endif

endmodule
`default_nettype wire

// File: doc/pattern_monitor.md
Name: pattern_monitor

Overview:
- Downstream consumer of the 3-phase serial state machine, whose `out` pattern is 1,0,0 repeating from reset.
- Aligns to that bit stream and declares lock after LOCK_N consecutive correct periods.
- Flags and counts bit errors while locked; drops lock after LOSS_N consecutive bad bits.
- Gives the lab bench a self-checking observer instead of hand-written per-clock checks.

Parameters:
- LOCK_N, 2: consecutive good 3-bit periods required to enter LOCKED (legal range 1..15).
- LOSS_N, 2: consecutive mismatching bits in LOCKED that force return to HUNT (legal range 1..15).
- CNT_W, 8: width of err_count and period_count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  sample enable; in_bit is consumed only on edges where in_valid=1.
- in_bit  in  1  serial bit from the upstream state machine.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle strobe for each mismatching bit consumed in LOCKED.
- err_count  out  CNT_W  LOCKED-state mismatches; saturates at all-ones.
- period_count  out  CNT_W  periods completed while LOCKED; wraps modulo 2^CNT_W.

Behaviour:
- Interface:
  - One clock. Reset is synchronous and active-high, with ports named clk and reset.
  - All outputs are registered.
- Reset:
  - state=HUNT, phase=0, good=0, bad=0.
  - locked=0, err_pulse=0, err_count=0, period_count=0.
  - Reset has priority over in_valid on the same edge.
  - Reset mid-operation discards alignment and counts immediately.
- Expected bit by phase: phase0=1, phase1=0, phase2=0. Phase advances 0→1→2→0 on each consumed bit.
- in_valid=0: nothing changes and err_pulse=0, i.e. a stall is invisible.
- HUNT:
  - Consumed 1: phase:=1, good:=0, go to CHECK.
  - Consumed 0: stay in HUNT.
- CHECK:
  - Match: advance phase.
  - Wrap 2→0 with good+1==LOCK_N: go to LOCKED with good:=0.
  - Wrap 2→0 otherwise: good++.
  - Mismatch with bit=1 (a 1 at phase1 or phase2): re-align in place, phase:=1, good:=0, stay in CHECK.
  - Mismatch with bit=0 (at phase0): go to HUNT.
  - No err_pulse is generated in CHECK.
- LOCKED (flywheel):
  - Phase always advances, match or not.
  - Match: bad:=0.
  - Mismatch: err_pulse=1 on the next cycle, err_count++ (saturating), bad++.
  - bad+1==LOSS_N: go to HUNT, locked falls on the same edge, phase:=0.
  - Every phase wrap 2→0 while remaining LOCKED: period_count++.
- Latency: the flag updates (locked, err_pulse, counts) are visible one cycle after the edge that consumed the bit.
- Simultaneous events:
  - Losing-lock mismatch on the wrap bit: counts the error, does not count the period.
  - LOCK_N=1: lock after the first full good period.
  - Wrap of period_count is silent. err_count holds at 2^CNT_W-1.

Optional Feature:
- Macro: PATTERN_MONITOR_HISTORY_EN.
- Defined:
  - Extra output `history [7:0]`: shift register of the last 8 consumed bits, newest in bit0, cleared on reset.
  - Extra output `first_err_phase [1:0]`: phase of the first LOCKED mismatch since reset, held; 2'b11 until one occurs.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package pattern_monitor_pkg holds:
  - state enum {HUNT, CHECK, LOCKED} (2-bit).
  - PERIOD=3.
  - Constant array EXPECTED[0:2] = {1,0,0}.
  - Function next_phase().
- One natural sub-module, sat_counter (parameter W; inputs inc, clr; saturating output), instanced for err_count.
- period_count is a plain wrapping counter inside the top.

Test Plan:
- Lock from reset: reset 2 cycles, then in_valid=1 with stream 1,0,0,1,0,0 → locked=1 exactly one cycle after the 6th bit; err_count=0; period_count=0.
- Steady count: 12 more correct bits after lock → period_count=4, err_pulse never high.
- Single error: after lock, bits 1,1,0,1,0,0 (error at phase1) → one err_pulse one cycle after the bad bit; err_count=1; locked stays 1.
- Lock loss: after lock, bits 0,1 at phase0 and phase1 → err_count=2, locked falls after the 2nd bad bit; then 1,0,0,1,0,0 → re-lock.
- Stall and re-align: in CHECK, toggle in_valid=0 for 5 cycles mid-period → no state change. Then 1,0,1,0,0,1,0,0 → re-align on the 3rd bit, lock after the 8th.
- Reset mid-lock plus saturation (CNT_W=2): 5 LOCKED errors each separated by a good bit → err_count=3 held. Assert reset → all outputs 0 the next cycle.
